// File: rtl/ternary_seq_multiplier_if.sv
// Trit encoding shared by the multiplier and its bench, plus the operand/product handshake bundle.
package ternary_seq_multiplier_pkg;
    typedef logic [1:0] trit_t;
    localparam trit_t T_ZERO = 2'b00;
    localparam trit_t T_POS  = 2'b01;
    localparam trit_t T_NEG  = 2'b10;
endpackage

interface ternary_seq_multiplier_if
    import ternary_seq_multiplier_pkg::*;
#(
    parameter int unsigned WIDTH = 9
);
    logic                    in_valid;
    logic                    in_ready;
    trit_t [WIDTH-1:0]       a;
    trit_t [WIDTH-1:0]       b;
    logic                    out_valid;
    logic                    out_ready;
    trit_t [2*WIDTH-1:0]     product;
    logic                    busy;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, product, busy
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, product, busy
    );
endinterface

// File: rtl/ternary_seq_multiplier.sv
// Balanced-ternary shift-add multiplier: one multiplier trit per cycle through a single ternary adder.
module ternary_seq_multiplier
    import ternary_seq_multiplier_pkg::*;
#(
    parameter int unsigned WIDTH = 9
) (
    input  logic                    clk,
    input  logic                    rst_n,
    ternary_seq_multiplier_if.slave bus
);
    localparam int unsigned CNT_W = $clog2(WIDTH + 1);
    localparam int unsigned ACC_W = 2 * WIDTH;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t              state_q, state_n;
    logic [CNT_W-1:0]    count_q, count_n;
    trit_t [WIDTH-1:0]   a_q, a_n;
    trit_t [WIDTH-1:0]   b_q, b_n;
    trit_t [ACC_W-1:0]   acc_q, acc_n;
    trit_t [ACC_W-1:0]   prod_q, prod_n;
    logic                out_valid_q, in_ready_q, busy_q;

    trit_t [WIDTH-1:0]   pp;
    trit_t [WIDTH-1:0]   cla_sum;
    trit_t               cla_cout;

    // Partial product: swapping the two encoding bits negates a trit
    always_comb begin
        pp = '0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            case (b_q[0])
                T_POS:   pp[i] = a_q[i];
                T_NEG:   pp[i] = {a_q[i][0], a_q[i][1]};
                default: pp[i] = T_ZERO;
            endcase
        end
    end

    ternary_cla #(.WIDTH(WIDTH)) u_cla (
        .a    (acc_q[ACC_W-1:WIDTH]),
        .b    (pp),
        .cin  (T_ZERO),
        .sum  (cla_sum),
        .cout (cla_cout)
    );

    always_comb begin
        state_n = state_q;
        count_n = count_q;
        a_n     = a_q;
        b_n     = b_q;
        acc_n   = acc_q;
        prod_n  = prod_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid && in_ready_q) begin
                    a_n     = bus.a;
                    b_n     = bus.b;
                    acc_n   = '0;
                    count_n = '0;
                    state_n = RUN;
                end
            end
            RUN: begin
                // acc[0] is final once shifted out, so the add only touches the upper half
                acc_n   = {cla_cout, cla_sum, acc_q[WIDTH-1:1]};
                b_n     = {T_ZERO, b_q[WIDTH-1:1]};
                count_n = CNT_W'(count_q + 1'b1);
                if (count_q == CNT_W'(WIDTH - 1)) begin
                    prod_n  = acc_n;
                    state_n = DONE;
                end
            end
            DONE: begin
                if (out_valid_q && bus.out_ready) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            count_q     <= '0;
            a_q         <= '0;
            b_q         <= '0;
            acc_q       <= '0;
            prod_q      <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_n;
            count_q     <= count_n;
            a_q         <= a_n;
            b_q         <= b_n;
            acc_q       <= acc_n;
            prod_q      <= prod_n;
            out_valid_q <= (state_n == DONE);
            in_ready_q  <= (state_n == IDLE);
            busy_q      <= (state_n != IDLE);
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.product   = prod_q;
    assign bus.busy      = busy_q;
endmodule

// Balanced-ternary adder; each trit's digit sum in [-3,3] folds into a digit and a carry in {-1,0,+1}.
module ternary_cla
    import ternary_seq_multiplier_pkg::*;
#(
    parameter int unsigned WIDTH = 9
) (
    input  trit_t [WIDTH-1:0] a,
    input  trit_t [WIDTH-1:0] b,
    input  trit_t             cin,
    output trit_t [WIDTH-1:0] sum,
    output trit_t             cout
);
    function automatic logic signed [2:0] t2i(input trit_t t);
        case (t)
            T_POS:   return 3'sd1;
            T_NEG:   return -3'sd1;
            default: return 3'sd0;
        endcase
    endfunction

    function automatic trit_t i2t(input logic signed [2:0] v);
        case (v)
            3'sd1:   return T_POS;
            -3'sd1:  return T_NEG;
            default: return T_ZERO;
        endcase
    endfunction

    logic signed [2:0] carry;
    logic signed [2:0] dsum;

    always_comb begin
        sum   = '0;
        dsum  = 3'sd0;
        carry = t2i(cin);
        for (int i = 0; i < int'(WIDTH); i++) begin
            dsum = t2i(a[i]) + t2i(b[i]) + carry;
            if (dsum > 3'sd1) begin
                sum[i] = i2t(dsum - 3'sd3);
                carry  = 3'sd1;
            end else if (dsum < -3'sd1) begin
                sum[i] = i2t(dsum + 3'sd3);
                carry  = -3'sd1;
            end else begin
                sum[i] = i2t(dsum);
                carry  = 3'sd0;
            end
        end
        cout = i2t(carry);
    end
endmodule

// File: tb/tb_ternary_seq_multiplier.sv
// Scoreboarded bench for ternary_seq_multiplier: integer golden products queued at issue, checked at output.
module tb_ternary_seq_multiplier;
    import ternary_seq_multiplier_pkg::*;

    localparam int unsigned W = 9;
    typedef trit_t [W-1:0]   op_t;
    typedef trit_t [2*W-1:0] prod_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ternary_seq_multiplier_if #(.WIDTH(W)) bus ();

    ternary_seq_multiplier #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    int     n_checks = 0;
    int     n_fail   = 0;
    int     n_in     = 0;
    int     n_out    = 0;
    longint sb[$];
    longint mon_exp;
    prod_t  last_prod;
    logic   stall_en = 1'b0;

    function automatic op_t to_op(input longint v);
        op_t    r;
        longint x;
        int     d;
        x = v;
        for (int i = 0; i < int'(W); i++) begin
            d = int'(((x % 3) + 3) % 3);
            if (d == 0) begin
                r[i] = T_ZERO;
            end else if (d == 1) begin
                r[i] = T_POS;
                x = x - 1;
            end else begin
                r[i] = T_NEG;
                x = x + 1;
            end
            x = x / 3;
        end
        return r;
    endfunction

    function automatic longint to_int(input prod_t p);
        longint s;
        s = 0;
        for (int i = 2 * int'(W) - 1; i >= 0; i--) begin
            s = s * 3 + ((p[i] == T_POS) ? 1 : ((p[i] == T_NEG) ? -1 : 0));
        end
        return s;
    endfunction

    function automatic prod_t neg(input prod_t p);
        prod_t r;
        for (int i = 0; i < 2 * int'(W); i++) r[i] = {p[i][0], p[i][1]};
        return r;
    endfunction

    // Output monitor: every product handshake is matched against the oldest queued golden value
    always @(negedge clk) begin
        if (rst_n && bus.out_valid && bus.out_ready) begin
            n_out++;
            n_checks++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_output: product=%0d with no operation pending", to_int(bus.product));
            end else begin
                mon_exp = sb.pop_front();
                if (to_int(bus.product) !== mon_exp) begin
                    n_fail++;
                    $display("FAIL product: got %0d expected %0d", to_int(bus.product), mon_exp);
                end
            end
            last_prod = bus.product;
        end
    end

    always @(posedge clk) begin
        if (stall_en) begin
            #1 bus.out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    task automatic issue(input longint x, input longint y);
        int t;
        t = 0;
        @(negedge clk);
        while (!bus.in_ready && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (!bus.in_ready) begin
            n_checks++;
            n_fail++;
            $display("FAIL issue_timeout: in_ready=%0b required 1", bus.in_ready);
            return;
        end
        bus.a = to_op(x);
        bus.b = to_op(y);
        bus.in_valid = 1'b1;
        sb.push_back(x * y);
        n_in++;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
    endtask

    task automatic wait_drain(input int max_cycles);
        int t;
        t = 0;
        while (sb.size() != 0 && t < max_cycles) begin
            @(negedge clk);
            t++;
        end
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL drain_timeout: %0d products outstanding, required 0", sb.size());
        end
    endtask

    task automatic test_reset();
        bus.in_valid = 1'b0;
        bus.a = '0;
        bus.b = '0;
        bus.out_ready = 1'b1;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %0b required 0", bus.out_valid); end
        n_checks++;
        if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %0b required 0", bus.busy); end
        n_checks++;
        if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %0b required 1", bus.in_ready); end
        n_checks++;
        if (bus.product !== prod_t'('0)) begin n_fail++; $display("FAIL reset_product: got %h required 0", bus.product); end
    endtask

    task automatic test_zero();
        int k;
        k = 0;
        bus.out_ready = 1'b1;
        issue(0, 0);
        @(negedge clk);
        n_checks++;
        if (bus.busy !== 1'b1 || bus.in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_run_flags: busy=%0b in_ready=%0b required 1/0", bus.busy, bus.in_ready);
        end
        while (!bus.out_valid && k < 20) begin
            @(negedge clk);
            k++;
        end
        n_checks++;
        if (k != 9) begin n_fail++; $display("FAIL zero_latency: out_valid after %0d cycles, required 9", k); end
        @(negedge clk);
        n_checks++;
        if (bus.in_ready !== 1'b1 || bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_return_idle: in_ready=%0b busy=%0b required 1/0", bus.in_ready, bus.busy);
        end
        wait_drain(50);
    endtask

    task automatic test_mixed_sign();
        bus.out_ready = 1'b1;
        issue(13, -14);
        issue(-14, 13);
        issue(-13, -14);
        wait_drain(100);
    endtask

    task automatic test_extremes();
        prod_t p1;
        bus.out_ready = 1'b1;
        issue(9841, 9841);
        wait_drain(50);
        p1 = last_prod;
        n_checks++;
        if (p1[2*W-1] === T_ZERO) begin n_fail++; $display("FAIL extreme_top_trit: got %b required nonzero", p1[2*W-1]); end
        issue(9841, -9841);
        wait_drain(50);
        n_checks++;
        if (last_prod !== neg(p1)) begin
            n_fail++;
            $display("FAIL extreme_negation: got %h required %h", last_prod, neg(p1));
        end
    endtask

    task automatic test_backpressure();
        int t;
        t = 0;
        bus.out_ready = 1'b0;
        issue(100, -27);
        while (!bus.out_valid && t < 40) begin
            @(negedge clk);
            t++;
        end
        n_checks++;
        if (!bus.out_valid) begin n_fail++; $display("FAIL bp_out_valid_timeout: got %0b required 1", bus.out_valid); end
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            n_checks++;
            if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_hold_valid: cycle %0d got %0b required 1", i, bus.out_valid); end
            n_checks++;
            if (to_int(bus.product) != -2700) begin n_fail++; $display("FAIL bp_hold_product: cycle %0d got %0d required -2700", i, to_int(bus.product)); end
            n_checks++;
            if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready: cycle %0d got %0b required 0", i, bus.in_ready); end
            bus.a = to_op(5);
            bus.b = to_op(5);
            bus.in_valid = (i % 2 == 1);
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_release: out_valid=%0b in_ready=%0b required 0/1", bus.out_valid, bus.in_ready);
        end
        wait_drain(20);
    endtask

    task automatic test_reset_mid();
        logic saw;
        saw = 1'b0;
        bus.out_ready = 1'b1;
        issue(364, 365);
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        n_checks++;
        if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_flags: out_valid=%0b busy=%0b required 0/0", bus.out_valid, bus.busy);
        end
        n_checks++;
        if (bus.product !== prod_t'('0)) begin n_fail++; $display("FAIL midreset_product: got %h required 0", bus.product); end
        sb.delete();
        n_in--;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (15) begin
            @(negedge clk);
            if (bus.out_valid) saw = 1'b1;
        end
        n_checks++;
        if (saw) begin n_fail++; $display("FAIL midreset_no_output: out_valid seen=%0b required 0", saw); end
        issue(40, 41);
        wait_drain(50);
    endtask

    task automatic test_random();
        longint x, y;
        stall_en = 1'b1;
        for (int i = 0; i < 200; i++) begin
            x = longint'(int'($urandom_range(0, 19682)) - 9841);
            y = longint'(int'($urandom_range(0, 19682)) - 9841);
            issue(x, y);
        end
        wait_drain(5000);
        stall_en = 1'b0;
        @(posedge clk);
        #1 bus.out_ready = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if (n_out != n_in) begin n_fail++; $display("FAIL output_count: got %0d outputs required %0d", n_out, n_in); end
    endtask

    initial begin
        test_reset();
        test_zero();
        test_mixed_sign();
        test_extremes();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
